// File: rtl/key_cmd_capture_if.sv
// key_cmd_capture_if
//   Valid/ready command channel between the key capture block and the
//   NeoPixel controller.
//   cmd_valid : source -> sink, holding slot occupied
//   cmd_data  : source -> sink, captured switch word (stable while valid)
//   cmd_ready : sink -> source, word accepted when valid && ready at a rising edge
interface key_cmd_capture_if #(
    parameter int SW_W = 5
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [SW_W-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/key_cmd_capture.sv
// key_cmd_capture
//   Debounces the synchronized, active-low KEY0. Each debounced press
//   captures the switch word into a 1-deep holding slot, which is offered
//   downstream over a valid/ready channel. Presses that find the slot
//   occupied (and not being emptied on that edge) are counted.
//   clock       : system clock, rising edge
//   reset       : asynchronous, active-high, clears all state
//   syncedKEY0  : synchronized key, 0 = pressed
//   syncedSW    : synchronized switch word
//   cmd_bus     : master side of the command channel (valid/data out, ready in)
//   key_pressed : debounced key level, 1 = pressed
//   dropped_cnt : saturating count of presses lost to a full slot
module key_cmd_capture #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SW_W            = 5,
    parameter int DROP_W          = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   syncedKEY0,
    input  logic [SW_W-1:0]        syncedSW,
    key_cmd_capture_if.master      cmd_bus,
    output logic                   key_pressed,
    output logic [DROP_W-1:0]      dropped_cnt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic            capture;
    logic            valid_q;
    logic [SW_W-1:0] data_q;

    // Debounce FSM next state. The counter holds how many consecutive
    // samples of the new level have been seen; with a one-cycle debounce
    // the WAIT states are skipped and the level change commits immediately.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (!syncedKEY0) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_next = PRESSED;
                        cnt_next   = CNT_ZERO;
                        capture    = 1'b1;
                    end else begin
                        state_next = PRESS_WAIT;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            PRESS_WAIT: begin
                if (syncedKEY0) begin
                    state_next = IDLE;
                    cnt_next   = CNT_ZERO;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSED;
                    cnt_next   = CNT_ZERO;
                    capture    = 1'b1;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (syncedKEY0) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_next = IDLE;
                        cnt_next   = CNT_ZERO;
                    end else begin
                        state_next = RELEASE_WAIT;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (!syncedKEY0) begin
                    state_next = PRESSED;
                    cnt_next   = CNT_ZERO;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = CNT_ZERO;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = CNT_ZERO;
            end
        endcase
    end

    // Debounce state and the registered debounced key level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= CNT_ZERO;
            key_pressed <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            key_pressed <= (state_next == PRESSED) || (state_next == RELEASE_WAIT);
        end
    end

    // Holding slot. A capture on the same edge the old word is accepted
    // reloads the slot; a capture into a slot that stays full is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            data_q      <= '0;
            dropped_cnt <= '0;
        end else if (capture) begin
            if (!valid_q || cmd_bus.cmd_ready) begin
                valid_q <= 1'b1;
                data_q  <= syncedSW;
            end else if (dropped_cnt != DROP_MAX) begin
                dropped_cnt <= dropped_cnt + 1'b1;
            end
        end else if (valid_q && cmd_bus.cmd_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign cmd_bus.cmd_valid = valid_q;
    assign cmd_bus.cmd_data  = data_q;

endmodule
